// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multi-cycle MIPS FSM and its datapath.
// Pure wiring, no latency of its own.
// Backpressure: mem_ready from the memory stalls the FSM in its memory states.
interface multicycle_controller_if;
  // datapath -> controller
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  // controller -> datapath
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] alu_control;
  logic [1:0] pc_src;
  logic       pc_write;
  logic       illegal_op;
  logic       mem_err;
  logic       instr_retired;
  logic [3:0] state_out;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_control, pc_src, pc_write, illegal_op,
           mem_err, instr_retired, state_out
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_control, pc_src, pc_write, illegal_op,
           mem_err, instr_retired, state_out
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute over a shared ALU and unified memory.
// Latency: R/addi/sw 4 cycles, lw 5, beq/j 3 (with mem_ready=1); each memory state adds one cycle per stall.
// Backpressure: FETCH/MEMRD/MEMWR hold their requests until mem_ready; TIMEOUT stalled cycles -> HALT + sticky mem_err.
module multicycle_controller #(
  parameter int TIMEOUT = 15
) (
  input  logic                    CLK,
  input  logic                    Reset,
  multicycle_controller_if.master bus
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12,
    S_HALT   = 4'd15
  } state_t;

  // State-decoded (Moore) part of the control word; registered alongside the state.
  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_control;
    logic [1:0] pc_src;
    logic       pc_write;
  } ctrl_t;

  state_t          state;
  state_t          nxt;
  ctrl_t           ctrl_q;
  logic [CW-1:0]   wait_cnt;
  logic            mem_err_q;
  logic            mem_wait;
  logic            timeout_hit;
  logic            ir_write_m;
  logic            pc_write_m;
  logic            illegal_m;
  logic            retire_m;

  function automatic logic funct_ok(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
           (fn == FN_OR)  || (fn == FN_SLT);
  endfunction

  // Unsupported functs fall back to add so the ALU still sees a defined op.
  function automatic logic [3:0] funct_alu(input logic [5:0] fn);
    logic [3:0] a;
    case (fn)
      FN_ADD:  a = ALU_ADD;
      FN_SUB:  a = ALU_SUB;
      FN_AND:  a = ALU_AND;
      FN_OR:   a = ALU_OR;
      FN_SLT:  a = ALU_SLT;
      default: a = ALU_ADD;
    endcase
    return a;
  endfunction

  // Control word for a state. funct is only consulted for EXEC; the IR is
  // already loaded when DECODE hands over, so it is stable at that edge.
  function automatic ctrl_t state_ctrl(input state_t s, input logic [5:0] fn);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read    = 1'b1;
        c.alu_src_b   = 2'b01;
        c.alu_control = ALU_ADD;
      end
      S_DECODE: begin
        c.alu_src_b   = 2'b11;
        c.alu_control = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        c.alu_src_a   = 1'b1;
        c.alu_src_b   = 2'b10;
        c.alu_control = ALU_ADD;
      end
      S_MEMRD: begin
        c.iord     = 1'b1;
        c.mem_read = 1'b1;
      end
      S_MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a   = 1'b1;
        c.alu_control = funct_alu(fn);
      end
      S_ALUWB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a   = 1'b1;
        c.alu_control = ALU_SUB;
        c.pc_src      = 2'b01;
      end
      S_ADDIWB: begin
        c.reg_write = 1'b1;
      end
      S_JUMP: begin
        c.pc_src   = 2'b10;
        c.pc_write = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  assign mem_wait    = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  // A completing access in the last allowed cycle wins over the timeout.
  assign timeout_hit = (TIMEOUT != 0) && mem_wait && !bus.mem_ready &&
                       (wait_cnt == CW'(TIMEOUT));

  // Next-state selection plus the input-dependent (Mealy) strobes.
  always_comb begin
    nxt        = state;
    ir_write_m = 1'b0;
    pc_write_m = 1'b0;
    illegal_m  = 1'b0;
    retire_m   = 1'b0;
    case (state)
      S_IDLE: nxt = S_FETCH;
      S_FETCH: begin
        if (bus.mem_ready) begin
          ir_write_m = 1'b1;
          pc_write_m = 1'b1;
          nxt        = S_DECODE;
        end else if (timeout_hit) begin
          nxt = S_HALT;
        end
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:     nxt = S_EXEC;
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_BEQ:       nxt = S_BRANCH;
          OP_ADDI:      nxt = S_ADDIEX;
          OP_J:         nxt = S_JUMP;
          default: begin
            illegal_m = 1'b1;
            nxt       = S_FETCH;
          end
        endcase
      end
      S_MEMADR: nxt = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (bus.mem_ready)  nxt = S_MEMWB;
        else if (timeout_hit) nxt = S_HALT;
      end
      S_MEMWB: begin
        retire_m = 1'b1;
        nxt      = S_FETCH;
      end
      S_MEMWR: begin
        if (bus.mem_ready) begin
          retire_m = 1'b1;
          nxt      = S_FETCH;
        end else if (timeout_hit) begin
          nxt = S_HALT;
        end
      end
      S_EXEC: begin
        if (funct_ok(bus.funct)) begin
          nxt = S_ALUWB;
        end else begin
          illegal_m = 1'b1;
          nxt       = S_FETCH;
        end
      end
      S_ALUWB, S_ADDIWB, S_JUMP: begin
        retire_m = 1'b1;
        nxt      = S_FETCH;
      end
      S_BRANCH: begin
        pc_write_m = bus.zero;
        retire_m   = 1'b1;
        nxt        = S_FETCH;
      end
      S_ADDIEX: nxt = S_ADDIWB;
      S_HALT:   nxt = S_HALT;
      default:  nxt = S_IDLE;
    endcase
  end

  // State, wait counter, sticky error and the registered Moore control word.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state     <= S_IDLE;
      ctrl_q    <= '0;
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state  <= nxt;
      ctrl_q <= state_ctrl(nxt, bus.funct);
      if (nxt != state) begin
        wait_cnt <= '0;
      end else if ((TIMEOUT != 0) && mem_wait && !bus.mem_ready) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (timeout_hit) begin
        mem_err_q <= 1'b1;
      end
    end
  end

  assign bus.iord          = ctrl_q.iord;
  assign bus.mem_read      = ctrl_q.mem_read;
  assign bus.mem_write     = ctrl_q.mem_write;
  assign bus.ir_write      = ir_write_m;
  assign bus.reg_dst       = ctrl_q.reg_dst;
  assign bus.mem_to_reg    = ctrl_q.mem_to_reg;
  assign bus.reg_write     = ctrl_q.reg_write;
  assign bus.alu_src_a     = ctrl_q.alu_src_a;
  assign bus.alu_src_b     = ctrl_q.alu_src_b;
  assign bus.alu_control   = ctrl_q.alu_control;
  assign bus.pc_src        = ctrl_q.pc_src;
  assign bus.pc_write      = ctrl_q.pc_write | pc_write_m;
  assign bus.illegal_op    = illegal_m;
  assign bus.mem_err       = mem_err_q;
  assign bus.instr_retired = retire_m;
  assign bus.state_out     = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed scenarios plus randomized instruction stream.
// Reference model walks each instruction's phase list and derives every output per cycle.
// Memory readiness is randomized; waits are kept below the timeout outside the timeout scenarios.
module tb_multicycle_controller;
  localparam int TO = 15;

  logic CLK = 1'b0;
  logic Reset;
  multicycle_controller_if bus();

  multicycle_controller #(.TIMEOUT(TO)) dut (.CLK(CLK), .Reset(Reset), .bus(bus));

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_control;
    logic [1:0] pc_src;
    logic       pc_write, illegal_op, mem_err, instr_retired;
    logic [3:0] state_out;
  } obs_t;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 0;

  // Reference model: phase number, cycles stalled in it, instruction class and path position.
  int m_phase, m_wait, m_cls, m_step;
  bit m_err, m_fetched;

  // Phase sequence after DECODE for: R, lw, sw, beq, addi, j.
  int paths [6][3] = '{'{7, 8, -1}, '{3, 4, 5}, '{3, 6, -1}, '{9, -1, -1}, '{10, 11, -1}, '{12, -1, -1}};

  logic [11:0] ir;
  logic [11:0] instr_q[$];

  function automatic int cls_of(input logic [5:0] op);
    case (op)
      6'b000000: return 0;
      6'b100011: return 1;
      6'b101011: return 2;
      6'b000100: return 3;
      6'b001000: return 4;
      6'b000010: return 5;
      default:   return -1;
    endcase
  endfunction

  function automatic int fn_code(input logic [5:0] fn);
    case (fn)
      6'b100000: return 2;
      6'b100010: return 6;
      6'b100100: return 0;
      6'b100101: return 1;
      6'b101010: return 7;
      default:   return -1;
    endcase
  endfunction

  function automatic int path_at(input int cls, input int idx);
    if (cls < 0 || cls > 5 || idx < 0 || idx > 2) return -1;
    return paths[cls][idx];
  endfunction

  function automatic bit is_mem_phase();
    return (m_phase == 1) || (m_phase == 4) || (m_phase == 6);
  endfunction

  function automatic bit timeout_now();
    return is_mem_phase() && !bus.mem_ready && (TO != 0) && (m_wait == TO);
  endfunction

  function automatic int path_next();
    int p;
    p = path_at(m_cls, m_step);
    return (p < 0) ? 1 : p;
  endfunction

  function automatic int next_phase();
    if (m_phase == 0)  return 1;
    if (m_phase == 15) return 15;
    if (is_mem_phase() && !bus.mem_ready) return timeout_now() ? 15 : m_phase;
    if (m_phase == 1)  return 2;
    if (m_phase == 2)  return (cls_of(bus.opcode) < 0) ? 1 : path_at(cls_of(bus.opcode), 0);
    if (m_phase == 7 && fn_code(bus.funct) < 0) return 1;
    return path_next();
  endfunction

  function automatic int next_step();
    if (m_phase == 2) return 1;
    if (next_phase() != m_phase) return m_step + 1;
    return m_step;
  endfunction

  always @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      m_phase   <= 0;
      m_wait    <= 0;
      m_cls     <= 0;
      m_step    <= 0;
      m_err     <= 0;
      m_fetched <= 0;
    end else begin
      m_fetched <= (m_phase == 1) && bus.mem_ready;
      m_err     <= m_err | timeout_now();
      m_cls     <= (m_phase == 2) ? cls_of(bus.opcode) : m_cls;
      m_step    <= next_step();
      m_wait    <= (next_phase() != m_phase) ? 0 :
                   ((is_mem_phase() && !bus.mem_ready) ? m_wait + 1 : m_wait);
      m_phase   <= next_phase();
    end
  end

  function automatic obs_t expected();
    obs_t e;
    int   c;
    e = '0;
    e.state_out = m_phase[3:0];
    e.mem_err   = m_err;
    case (m_phase)
      1:  begin e.mem_read = 1; e.alu_src_b = 2'b01; e.alu_control = 4'b0010;
                e.ir_write = bus.mem_ready; e.pc_write = bus.mem_ready; end
      2:  begin e.alu_src_b = 2'b11; e.alu_control = 4'b0010;
                e.illegal_op = (cls_of(bus.opcode) < 0); end
      3, 10: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_control = 4'b0010; end
      4:  begin e.iord = 1; e.mem_read = 1; end
      5:  begin e.mem_to_reg = 1; e.reg_write = 1; e.instr_retired = 1; end
      6:  begin e.iord = 1; e.mem_write = 1; e.instr_retired = bus.mem_ready; end
      7:  begin
            e.alu_src_a = 1;
            c = fn_code(bus.funct);
            if (c < 0) begin e.illegal_op = 1; e.alu_control = 4'b0010; end
            else e.alu_control = c[3:0];
          end
      8:  begin e.reg_dst = 1; e.reg_write = 1; e.instr_retired = 1; end
      9:  begin e.alu_src_a = 1; e.alu_control = 4'b0110; e.pc_src = 2'b01;
                e.pc_write = bus.zero; e.instr_retired = 1; end
      11: begin e.reg_write = 1; e.instr_retired = 1; end
      12: begin e.pc_src = 2'b10; e.pc_write = 1; e.instr_retired = 1; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic obs_t actual();
    return {bus.iord, bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_dst, bus.mem_to_reg,
            bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_control, bus.pc_src,
            bus.pc_write, bus.illegal_op, bus.mem_err, bus.instr_retired, bus.state_out};
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge CLK) begin
    obs_t e;
    obs_t a;
    if (chk_en) begin
      e = expected();
      a = actual();
      n_total++;
      if (a === e) n_pass++;
      else $display("FAIL cycle_outputs t=%0t got %h exp %h", $time, a, e);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %0h exp %0h", name, got, exp);
  endtask

  function automatic logic [5:0] legal_fn(input int k);
    case (k)
      0: return 6'b100000;
      1: return 6'b100010;
      2: return 6'b100100;
      3: return 6'b100101;
      default: return 6'b101010;
    endcase
  endfunction

  function automatic logic [11:0] rand_instr();
    int r;
    r = $urandom_range(0, 11);
    case (r)
      0, 1, 2: return {6'b000000, legal_fn($urandom_range(0, 4))};
      3:       return {6'b000000, 6'($urandom)};
      4:       return {6'b100011, 6'($urandom)};
      5:       return {6'b101011, 6'($urandom)};
      6, 7:    return {6'b000100, 6'($urandom)};
      8:       return {6'b001000, 6'($urandom)};
      9:       return {6'b000010, 6'($urandom)};
      10:      return {6'b111111, 6'($urandom)};
      default: return {6'b001101, 6'($urandom)};
    endcase
  endfunction

  // One clock: inputs for the coming cycle are applied just after the edge;
  // the IR reloads whenever the previous cycle completed a fetch.
  task automatic step(input logic rdy, input logic z);
    @(posedge CLK);
    #1;
    if (m_fetched) begin
      if (instr_q.size() > 0) ir = instr_q.pop_front();
      else ir = rand_instr();
    end
    bus.opcode    = ir[11:6];
    bus.funct     = ir[5:0];
    bus.mem_ready = rdy;
    bus.zero      = z;
    @(negedge CLK);
    #1;
  endtask

  task automatic hold_reset(input logic rdy);
    Reset = 1'b1;
    bus.mem_ready = rdy;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1);
  end

  initial begin
    Reset = 1'b1;
    ir = '0;
    bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1 chk_en = 1;
    @(negedge CLK); #1;
    check("reset_all_outputs_zero", 32'(actual()), 32'h0);

    // R-type add, memory always ready.
    instr_q.push_back({6'b000000, 6'b100000});
    bus.mem_ready = 1'b1;
    Reset = 1'b0;
    check("A_idle_state", 32'(bus.state_out), 0);
    step(1, 0); check("A_fetch_state", 32'(bus.state_out), 1);
    check("A_fetch_ir_write", 32'(bus.ir_write), 1);
    step(1, 0); check("A_decode_state", 32'(bus.state_out), 2);
    step(1, 0); check("A_exec_state", 32'(bus.state_out), 7);
    check("A_exec_alu_add", 32'(bus.alu_control), 32'b0010);
    step(1, 0); check("A_aluwb_state", 32'(bus.state_out), 8);
    check("A_aluwb_dst_wr_ret", 32'({bus.reg_dst, bus.reg_write, bus.instr_retired}), 32'b111);

    // lw with three stalled cycles in MEMRD.
    instr_q.push_back({6'b100011, 6'b000000});
    step(1, 0); step(1, 0);
    step(0, 0); check("B_memadr_state", 32'(bus.state_out), 3);
    for (int i = 0; i < 3; i++) begin
      step(0, 0);
      check("B_memrd_stall_state", 32'(bus.state_out), 4);
      check("B_memrd_stall_req", 32'({bus.mem_read, bus.iord}), 32'b11);
    end
    step(1, 0); check("B_memrd_ready_state", 32'(bus.state_out), 4);
    step(1, 0); check("B_memwb_state", 32'(bus.state_out), 5);
    check("B_memwb_m2r_wr_ret", 32'({bus.mem_to_reg, bus.reg_write, bus.instr_retired}), 32'b111);

    // beq taken then not taken.
    instr_q.push_back({6'b000100, 6'b000000});
    instr_q.push_back({6'b000100, 6'b000000});
    step(1, 0); step(1, 0);
    step(1, 1); check("C_taken_pcw_src_ret", 32'({bus.pc_write, bus.pc_src, bus.instr_retired}), 32'b1011);
    step(1, 0); check("C_back_to_fetch", 32'(bus.state_out), 1);
    step(1, 0);
    step(1, 0); check("C_nottaken_pcw_src_ret", 32'({bus.pc_write, bus.pc_src, bus.instr_retired}), 32'b0011);

    // Illegal opcode.
    instr_q.push_back({6'b111111, 6'b000000});
    step(1, 0); step(1, 0);
    check("D_illegal_pulse", 32'({bus.illegal_op, bus.reg_write, bus.instr_retired}), 32'b100);
    step(1, 0); check("D_next_fetch", 32'(bus.state_out), 1);
    check("D_illegal_cleared", 32'(bus.illegal_op), 0);

    // Randomized stream; stalls capped well under the timeout.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) != 0 || m_wait >= 10) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)));
    end
    check("rand_no_mem_err", 32'(bus.mem_err), 0);

    // Fetch stalls 16 cycles -> HALT with sticky mem_err.
    hold_reset(0);
    Reset = 1'b0;
    for (int i = 0; i < 16; i++) step(0, 0);
    check("E_fetch_cycle16_state", 32'(bus.state_out), 1);
    step(0, 0); check("E_halt_word", 32'(actual()), 32'h2F);
    for (int i = 0; i < 3; i++) begin
      step(1, 0); check("E_halt_sticky", 32'(actual()), 32'h2F);
    end
    #2 Reset = 1'b1;
    #1 check("E_async_reset_clears", 32'(actual()), 32'h0);

    // Ready arriving on the 16th fetch cycle beats the timeout.
    instr_q.push_back({6'b000010, 6'b000000});
    hold_reset(0);
    Reset = 1'b0;
    for (int i = 0; i < 15; i++) step(0, 0);
    step(1, 0); check("F_ready16_ir_write", 32'({bus.state_out, bus.ir_write}), 32'b00011);
    step(1, 0); check("F_decode_no_err", 32'({bus.state_out, bus.mem_err}), 32'b00100);
    step(1, 0); check("F_jump_pcw_src_ret", 32'({bus.pc_write, bus.pc_src, bus.instr_retired}), 32'b1101);

    // Reset while sw is waiting in MEMWR.
    instr_q.push_back({6'b101011, 6'b000000});
    step(1, 0); step(1, 0); step(0, 0);
    step(0, 0); check("G_memwr_req", 32'({bus.state_out, bus.iord, bus.mem_write}), 32'b011011);
    step(0, 0);
    #2 Reset = 1'b1;
    #1 check("G_async_reset_outputs", 32'(actual()), 32'h0);
    hold_reset(1);
    Reset = 1'b0;
    step(1, 0); check("G_restart_fetch", 32'(bus.state_out), 1);
    step(1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
